// File: rtl/registers_bram_mt_pkg.sv
// Shared definitions for the per-thread BRAM register file:
// FSM encodings and the MSB helper used to size addresses.
package registers_bram_mt_pkg;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  // Index of the highest set bit; 0 for an argument of 0 or 1.
  function automatic int msb(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((v >> i) != 0) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/registers_bram_mt_rd_port.sv
// One BRAM copy with its 2-stage read pipeline and
// same-cycle write-to-read bypass.
module registers_bram_mt_rd_port #(
  parameter int WIDTH = 32,
  parameter int IW    = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [IW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re0_i,
  input  logic             re1_i,
  input  logic [IW-1:0]    raddr_i,
  output logic [WIDTH-1:0] dout_o
);

  localparam int DEPTH = 1 << IW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] s0_q;
  logic [WIDTH-1:0] s0_d;
  logic [WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read-first array: a write to the read index is taken from the port.
  always_comb begin
    s0_d = mem_q[raddr_i];
    if (we_i && (waddr_i == raddr_i)) s0_d = wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q   <= '0;
      dout_q <= '0;
    end else begin
      if (re0_i) s0_q <= s0_d;
      if (re1_i) dout_q <= s0_q;
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/registers_bram_mt.sv
// Per-thread register file: two BRAM read copies, one shared write
// port with a memory-load holding buffer, and hardware init/clear.
module registers_bram_mt
  import registers_bram_mt_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int N_THREADS     = 6,
  parameter int N_REGS        = 16,
  parameter int REG_ADDR_MSB  = msb(N_REGS - 1),
  parameter int N_THREADS_MSB = msb(N_THREADS - 1)
) (
  input  logic                    CLK,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        din,
  input  logic                    wr_en,
  input  logic [REG_ADDR_MSB:0]   wr_addr,
  input  logic [N_THREADS_MSB:0]  wr_thread_num,
  input  logic [WIDTH-1:0]        mem_din,
  input  logic                    mem_wr_en,
  input  logic [REG_ADDR_MSB:0]   mem_wr_addr,
  input  logic [N_THREADS_MSB:0]  mem_wr_thread_num,
  output logic                    mem_wr_ready,
  input  logic [N_THREADS_MSB:0]  rd_thread_num_a,
  input  logic [N_THREADS_MSB:0]  rd_thread_num_b,
  input  logic [REG_ADDR_MSB:0]   rd_addr_a,
  input  logic [REG_ADDR_MSB:0]   rd_addr_b,
  input  logic                    rd_en0_a,
  input  logic                    rd_en0_b,
  input  logic                    rd_en1_a,
  input  logic                    rd_en1_b,
  output logic [WIDTH-1:0]        dout_a,
  output logic [WIDTH-1:0]        dout_b,
  input  logic                    clr_en,
  input  logic [N_THREADS_MSB:0]  clr_thread_num,
  output logic                    ready,
  output logic                    err
);

  localparam int TW    = N_THREADS_MSB + 1;
  localparam int RW    = REG_ADDR_MSB + 1;
  localparam int IW    = TW + RW;
  localparam int TOTAL = N_THREADS * N_REGS;
  localparam int CW    = msb(TOTAL - 1) + 1;

  localparam logic [CW-1:0] INIT_LAST = CW'(TOTAL - 1);
  localparam logic [RW-1:0] CLR_LAST  = {RW{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    clr_thr_q, clr_thr_d;
  logic             buf_v_q, buf_v_d;
  logic [IW-1:0]    buf_idx_q, buf_idx_d;
  logic [WIDTH-1:0] buf_dat_q, buf_dat_d;
  logic             err_q, err_d;

  logic             we;
  logic [IW-1:0]    widx;
  logic [WIDTH-1:0] wdat;
  logic             drop;
  logic             mem_acc;
  logic [IW-1:0]    mem_idx;
  logic             is_init;
  logic             is_clear;

  assign mem_idx  = {mem_wr_thread_num, mem_wr_addr};
  assign mem_acc  = mem_wr_en && !buf_v_q;
  assign is_init  = (state_q == ST_INIT);
  assign is_clear = (state_q == ST_CLEAR);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_thr_d = clr_thr_q;
    buf_v_d   = buf_v_q;
    buf_idx_d = buf_idx_q;
    buf_dat_d = buf_dat_q;
    we        = 1'b0;
    widx      = '0;
    wdat      = '0;
    drop      = mem_wr_en && buf_v_q;

    unique case (1'b1)
      is_init: begin
        we   = 1'b1;
        widx = IW'(cnt_q);
        if (cnt_q == INIT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (wr_en || clr_en) drop = 1'b1;
        if (mem_acc) begin
          buf_v_d   = 1'b1;
          buf_idx_d = mem_idx;
          buf_dat_d = mem_din;
        end
      end
      is_clear: begin
        we   = 1'b1;
        widx = {clr_thr_q, cnt_q[RW-1:0]};
        if (cnt_q[RW-1:0] == CLR_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (wr_en || clr_en) drop = 1'b1;
        if (mem_acc) begin
          buf_v_d   = 1'b1;
          buf_idx_d = mem_idx;
          buf_dat_d = mem_din;
        end
      end
      default: begin
        if (clr_en) begin
          state_d   = ST_CLEAR;
          cnt_d     = '0;
          clr_thr_d = clr_thread_num;
        end
        // ALU wins; a colliding load parks in the buffer.
        if (wr_en) begin
          we   = 1'b1;
          widx = {wr_thread_num, wr_addr};
          wdat = din;
          if (mem_acc) begin
            buf_v_d   = 1'b1;
            buf_idx_d = mem_idx;
            buf_dat_d = mem_din;
          end
        end else if (buf_v_q) begin
          we      = 1'b1;
          widx    = buf_idx_q;
          wdat    = buf_dat_q;
          buf_v_d = 1'b0;
        end else if (mem_acc) begin
          we   = 1'b1;
          widx = mem_idx;
          wdat = mem_din;
        end
      end
    endcase

    err_d = err_q || drop;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      clr_thr_q <= '0;
      buf_v_q   <= 1'b0;
      buf_idx_q <= '0;
      buf_dat_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clr_thr_q <= clr_thr_d;
      buf_v_q   <= buf_v_d;
      buf_idx_q <= buf_idx_d;
      buf_dat_q <= buf_dat_d;
      err_q     <= err_d;
    end
  end

  assign ready        = (state_q == ST_IDLE);
  assign err          = err_q;
  assign mem_wr_ready = !buf_v_q;

  registers_bram_mt_rd_port #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_port_a (
    .clk     (CLK),
    .rst_n   (rst_n),
    .we_i    (we),
    .waddr_i (widx),
    .wdata_i (wdat),
    .re0_i   (rd_en0_a),
    .re1_i   (rd_en1_a),
    .raddr_i ({rd_thread_num_a, rd_addr_a}),
    .dout_o  (dout_a)
  );

  registers_bram_mt_rd_port #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_port_b (
    .clk     (CLK),
    .rst_n   (rst_n),
    .we_i    (we),
    .waddr_i (widx),
    .wdata_i (wdat),
    .re0_i   (rd_en0_b),
    .re1_i   (rd_en1_b),
    .raddr_i ({rd_thread_num_b, rd_addr_b}),
    .dout_o  (dout_b)
  );

endmodule
